alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 134 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Single-issue controller: 4x4 register file, carry flag, and a
// three-state IDLE/EXEC/RESP sequencer feeding an external ALU.
module alu_issue_ctrl #(
    parameter bit QUIET_IDLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [11:0] instr,
    input  logic        ld_en,
    input  logic [1:0]  ld_addr,
    input  logic [3:0]  ld_data,
    output logic        ld_ready,
    output logic        alu_s0,
    output logic        alu_s1,
    output logic        alu_s2,
    output logic        alu_s3,
    output logic        alu_cin,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    input  logic [3:0]  alu_f,
    input  logic        alu_cout,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [3:0]  res_data,
    output logic        res_cout,
    output logic        res_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0][3:0]   rf_q, rf_d;
    logic              c_q, c_d;
    logic [11:0]       op_q, op_d;
    logic [3:0]        res_data_q, res_data_d;
    logic              res_cout_q, res_cout_d;
    logic              res_zero_q, res_zero_d;

    logic              op_use_c;
    logic [3:0]        op_sel;
    logic              op_cin;
    logic [1:0]        op_rd;
    logic [1:0]        op_ra;
    logic [1:0]        op_rb;
    logic              drive;

    assign op_use_c = op_q[11];
    assign op_sel   = op_q[10:7];
    assign op_cin   = op_q[6];
    assign op_rd    = op_q[5:4];
    assign op_ra    = op_q[3:2];
    assign op_rb    = op_q[1:0];

    // Operands are always read from the pre-writeback register file.
    assign drive = (state_q == EXEC) || (QUIET_IDLE == 1'b0);

    assign alu_a   = drive ? rf_q[op_ra] : 4'h0;
    assign alu_b   = drive ? rf_q[op_rb] : 4'h0;
    assign alu_s3  = drive & op_sel[3];
    assign alu_s2  = drive & op_sel[2];
    assign alu_s1  = drive & op_sel[1];
    assign alu_s0  = drive & op_sel[0];
    assign alu_cin = drive & (op_use_c ? c_q : op_cin);

    assign ld_ready    = (state_q == IDLE);
    assign instr_ready = (state_q == IDLE) & ~ld_en;
    assign res_valid   = (state_q == RESP);
    assign res_data    = res_data_q;
    assign res_cout    = res_cout_q;
    assign res_zero    = res_zero_q;

    always_comb begin
        state_d    = state_q;
        rf_d       = rf_q;
        c_d        = c_q;
        op_d       = op_q;
        res_data_d = res_data_q;
        res_cout_d = res_cout_q;
        res_zero_d = res_zero_q;
        unique case (state_q)
            IDLE: begin
                if (ld_en) begin
                    rf_d[ld_addr] = ld_data;
                end else if (instr_valid) begin
                    op_d    = instr;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rf_d[op_rd] = alu_f;
                c_d         = alu_cout;
                res_data_d  = alu_f;
                res_cout_d  = alu_cout;
                res_zero_d  = (alu_f == 4'h0);
                state_d     = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rf_q       <= '0;
            c_q        <= 1'b0;
            op_q       <= '0;
            res_data_q <= 4'h0;
            res_cout_q <= 1'b0;
            res_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rf_q       <= rf_d;
            c_q        <= c_d;
            op_q       <= op_d;
            res_data_q <= res_data_d;
            res_cout_q <= res_cout_d;
            res_zero_q <= res_zero_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a register-file and
// carry-flag reference model; the ALU is a bench-driven stub.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [11:0] instr;
    logic        ld_en;
    logic [1:0]  ld_addr;
    logic [3:0]  ld_data;
    logic        ld_ready;
    logic        alu_s0, alu_s1, alu_s2, alu_s3, alu_cin;
    logic [3:0]  alu_a, alu_b, alu_f;
    logic        alu_cout;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_data;
    logic        res_cout;
    logic        res_zero;

    int tests = 0;
    int fails = 0;

    logic [3:0] m_r [4];
    logic       m_c;

    alu_issue_ctrl #(.QUIET_IDLE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_s2(alu_s2), .alu_s3(alu_s3),
        .alu_cin(alu_cin), .alu_a(alu_a), .alu_b(alu_b),
        .alu_f(alu_f), .alu_cout(alu_cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_cout(res_cout), .res_zero(res_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] mk(input logic uc, input logic [3:0] s,
        input logic ci, input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb);
        return {uc, s, ci, rd, ra, rb};
    endfunction

    // Reference: operands from the old file, then writeback of the stub result.
    function automatic void predict(input logic [11:0] ins, input logic [3:0] f,
        input logic co, output logic [3:0] ea, output logic [3:0] eb, output logic ec);
        ea = m_r[ins[3:2]];
        eb = m_r[ins[1:0]];
        ec = ins[11] ? m_c : ins[6];
        m_r[ins[5:4]] = f;
        m_c = co;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 4'h0;
        m_c = 1'b0;
    endfunction

    task automatic do_load(input logic [1:0] a, input logic [3:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
        m_r[a] = d;
    endtask

    task automatic issue(input logic [11:0] ins, input logic [3:0] f, input logic co,
        output logic rdy, output logic [3:0] a, output logic [3:0] b,
        output logic [3:0] s, output logic ci, output logic rv_e, output logic rv_r,
        output logic [3:0] rd_o, output logic rc, output logic rz);
        @(negedge clk);
        instr = ins; instr_valid = 1'b1; alu_f = f; alu_cout = co; res_ready = 1'b1;
        #1 rdy = instr_ready;
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        a = alu_a; b = alu_b; s = {alu_s3, alu_s2, alu_s1, alu_s0};
        ci = alu_cin; rv_e = res_valid;
        @(negedge clk);
        #1;
        rv_r = res_valid; rd_o = res_data; rc = res_cout; rz = res_zero;
    endtask

    task automatic read_reg(input logic [1:0] r, output logic [3:0] v);
        logic rdy, ci, rve, rvr, rc, rz;
        logic [3:0] b, s, rd;
        issue(mk(1'b0, 4'h0, 1'b0, r, r, r), m_r[r], m_c,
              rdy, v, b, s, ci, rve, rvr, rd, rc, rz);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; ld_en = 1'b0;
        ld_addr = '0; ld_data = '0; alu_f = '0; alu_cout = 1'b0; res_ready = 1'b0;
        model_reset();
        #2;
        tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL rst_res_valid: got %b exp 0", res_valid); end
        tests++; if ({res_data, res_cout, res_zero} !== 6'h0) begin fails++; $display("FAIL rst_res: got %h exp 00", {res_data, res_cout, res_zero}); end
        tests++; if (instr_ready !== 1'b1 || ld_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b%b exp 11", instr_ready, ld_ready); end
        tests++; if (alu_a !== 4'h0 || alu_cin !== 1'b0) begin fails++; $display("FAIL rst_quiet: got %h/%b exp 0/0", alu_a, alu_cin); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        instr = mk(1'b0, 4'h0, 1'b1, 2'd0, 2'd0, 2'd0);
        instr_valid = 1'b1; alu_f = 4'h0; alu_cout = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        tests++; if (res_valid !== 1'b0 || alu_cin !== 1'b1) begin fails++; $display("FAIL first_accept_exec: got rv=%b cin=%b exp rv=0 cin=1", res_valid, alu_cin); end
        @(negedge clk);
        #1;
        tests++; if (res_valid !== 1'b1 || res_zero !== 1'b1) begin fails++; $display("FAIL first_accept_resp: got rv=%b z=%b exp 1/1", res_valid, res_zero); end
    endtask

    task automatic test_basic();
        logic rdy, ci, rve, rvr, rc, rz, ec;
        logic [3:0] a, b, s, rd, ea, eb, v;
        do_load(2'd1, 4'h3);
        do_load(2'd2, 4'h5);
        predict(mk(1'b0, 4'h0, 1'b1, 2'd0, 2'd1, 2'd2), 4'h9, 1'b0, ea, eb, ec);
        issue(mk(1'b0, 4'h0, 1'b1, 2'd0, 2'd1, 2'd2), 4'h9, 1'b0,
              rdy, a, b, s, ci, rve, rvr, rd, rc, rz);
        tests++; if (a !== 4'h3 || b !== 4'h5) begin fails++; $display("FAIL basic_ops: got %h,%h exp 3,5", a, b); end
        tests++; if (ci !== 1'b1) begin fails++; $display("FAIL basic_cin: got %b exp 1", ci); end
        tests++; if (rve !== 1'b0 || rvr !== 1'b1) begin fails++; $display("FAIL basic_latency: got %b%b exp 01", rve, rvr); end
        tests++; if (rd !== 4'h9 || rc !== 1'b0 || rz !== 1'b0) begin fails++; $display("FAIL basic_res: got %h %b %b exp 9 0 0", rd, rc, rz); end
        read_reg(2'd0, v);
        tests++; if (v !== 4'h9) begin fails++; $display("FAIL basic_r0: got %h exp 9", v); end
    endtask

    task automatic test_carry_chain();
        logic rdy, ci, rve, rvr, rc, rz, ec;
        logic [3:0] a, b, s, rd, ea, eb;
        predict(mk(1'b0, 4'hA, 1'b0, 2'd3, 2'd1, 2'd2), 4'h1, 1'b1, ea, eb, ec);
        issue(mk(1'b0, 4'hA, 1'b0, 2'd3, 2'd1, 2'd2), 4'h1, 1'b1,
              rdy, a, b, s, ci, rve, rvr, rd, rc, rz);
        tests++; if (s !== 4'hA || rc !== 1'b1) begin fails++; $display("FAIL chain1: got s=%h c=%b exp A 1", s, rc); end
        predict(mk(1'b1, 4'h5, 1'b0, 2'd2, 2'd3, 2'd1), 4'h7, 1'b0, ea, eb, ec);
        issue(mk(1'b1, 4'h5, 1'b0, 2'd2, 2'd3, 2'd1), 4'h7, 1'b0,
              rdy, a, b, s, ci, rve, rvr, rd, rc, rz);
        tests++; if (ci !== 1'b1) begin fails++; $display("FAIL chain2_cin: got %b exp 1", ci); end
        tests++; if (a !== ea || b !== eb) begin fails++; $display("FAIL chain2_ops: got %h,%h exp %h,%h", a, b, ea, eb); end
        predict(mk(1'b1, 4'h0, 1'b1, 2'd0, 2'd0, 2'd0), 4'h2, 1'b0, ea, eb, ec);
        issue(mk(1'b1, 4'h0, 1'b1, 2'd0, 2'd0, 2'd0), 4'h2, 1'b0,
              rdy, a, b, s, ci, rve, rvr, rd, rc, rz);
        tests++; if (ci !== 1'b0) begin fails++; $display("FAIL chain3_cin: got %b exp 0", ci); end
    endtask

    task automatic test_backpressure();
        logic [3:0] held, v;
        logic ec;
        logic [3:0] ea, eb;
        logic bad_v, bad_d, bad_r;
        bad_v = 1'b0; bad_d = 1'b0; bad_r = 1'b0;
        predict(mk(1'b0, 4'h3, 1'b0, 2'd1, 2'd0, 2'd2), 4'hC, 1'b1, ea, eb, ec);
        @(negedge clk);
        instr = mk(1'b0, 4'h3, 1'b0, 2'd1, 2'd0, 2'd2);
        instr_valid = 1'b1; alu_f = 4'hC; alu_cout = 1'b1; res_ready = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        #1 held = res_data;
        for (int i = 0; i < 5; i++) begin
            ld_en = 1'b1; ld_addr = 2'($urandom_range(0, 3)); ld_data = 4'($urandom);
            #1;
            if (res_valid !== 1'b1) bad_v = 1'b1;
            if (res_data !== held) bad_d = 1'b1;
            if (instr_ready !== 1'b0) bad_r = 1'b1;
            @(negedge clk);
        end
        ld_en = 1'b0; res_ready = 1'b1;
        tests++; if (held !== 4'hC) begin fails++; $display("FAIL bp_data: got %h exp c", held); end
        tests++; if (bad_v | bad_d | bad_r) begin fails++; $display("FAIL bp_stable: got v/d/r flags %b%b%b exp 000", bad_v, bad_d, bad_r); end
        for (int r = 0; r < 4; r++) begin
            read_reg(2'(r), v);
            tests++; if (v !== m_r[r]) begin fails++; $display("FAIL bp_reg%0d: got %h exp %h", r, v, m_r[r]); end
        end
    endtask

    task automatic test_load_priority();
        logic [3:0] v;
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 2'd2; ld_data = 4'hE;
        instr = mk(1'b0, 4'h0, 1'b0, 2'd3, 2'd2, 2'd2);
        instr_valid = 1'b1; alu_f = 4'h4; alu_cout = 1'b0; res_ready = 1'b1;
        #1;
        tests++; if (instr_ready !== 1'b0 || ld_ready !== 1'b1) begin fails++; $display("FAIL lp_ready: got %b%b exp 01", instr_ready, ld_ready); end
        m_r[2] = 4'hE;
        @(negedge clk);
        ld_en = 1'b0;
        #1;
        tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL lp_next_ready: got %b exp 1", instr_ready); end
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        tests++; if (alu_a !== 4'hE) begin fails++; $display("FAIL lp_exec: got %h exp e", alu_a); end
        m_r[3] = 4'h4; m_c = 1'b0;
        @(negedge clk);
        read_reg(2'd3, v);
        tests++; if (v !== 4'h4) begin fails++; $display("FAIL lp_r3: got %h exp 4", v); end
    endtask

    task automatic test_rd_eq_ra();
        logic rdy, ci, rve, rvr, rc, rz, ec;
        logic [3:0] a, b, s, rd, ea, eb, v;
        do_load(2'd1, 4'h6);
        predict(mk(1'b0, 4'h9, 1'b0, 2'd1, 2'd1, 2'd1), 4'h0, 1'b0, ea, eb, ec);
        issue(mk(1'b0, 4'h9, 1'b0, 2'd1, 2'd1, 2'd1), 4'h0, 1'b0,
              rdy, a, b, s, ci, rve, rvr, rd, rc, rz);
        tests++; if (a !== 4'h6) begin fails++; $display("FAIL rdra_a: got %h exp 6", a); end
        tests++; if (rz !== 1'b1) begin fails++; $display("FAIL rdra_zero: got %b exp 1", rz); end
        read_reg(2'd1, v);
        tests++; if (v !== 4'h0) begin fails++; $display("FAIL rdra_r1: got %h exp 0", v); end
    endtask

    task automatic test_reset_exec();
        logic [3:0] v;
        do_load(2'd1, 4'h7);
        do_load(2'd2, 4'h3);
        @(negedge clk);
        instr = mk(1'b0, 4'h0, 1'b0, 2'd1, 2'd1, 2'd2);
        instr_valid = 1'b1; alu_f = 4'hB; alu_cout = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests++; if (res_valid !== 1'b0 || res_data !== 4'h0) begin fails++; $display("FAIL rx_outputs: got %b %h exp 0 0", res_valid, res_data); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL rx_ready: got %b exp 1", instr_ready); end
        for (int r = 0; r < 4; r++) begin
            read_reg(2'(r), v);
            tests++; if (v !== 4'h0) begin fails++; $display("FAIL rx_reg%0d: got %h exp 0", r, v); end
        end
        issue(mk(1'b1, 4'h0, 1'b0, 2'd0, 2'd0, 2'd0), 4'h0, 1'b0,
              v[0], v, v, v, v[1], v[2], v[3], v, v[0], v[1]);
    endtask

    task automatic test_random();
        logic rdy, ci, rve, rvr, rc, rz, ec;
        logic [3:0] a, b, s, rd, ea, eb, f;
        logic [11:0] ins;
        logic co;
        int bad;
        model_reset();
        for (int r = 0; r < 4; r++) do_load(2'(r), 4'h0);
        // C from the reset-exec tail instruction is 0 already
        for (int n = 0; n < 40; n++) begin
            bad = 0;
            if ($urandom_range(0, 1) == 1) do_load(2'($urandom_range(0, 3)), 4'($urandom));
            ins = 12'($urandom);
            f = 4'($urandom);
            co = 1'($urandom);
            predict(ins, f, co, ea, eb, ec);
            issue(ins, f, co, rdy, a, b, s, ci, rve, rvr, rd, rc, rz);
            tests++; if (a !== ea || b !== eb) begin fails++; $display("FAIL rand%0d_ops: got %h,%h exp %h,%h", n, a, b, ea, eb); end
            tests++; if (s !== ins[10:7] || ci !== ec) begin fails++; $display("FAIL rand%0d_ctl: got %h/%b exp %h/%b", n, s, ci, ins[10:7], ec); end
            tests++; if (rd !== f || rc !== co || rz !== (f == 4'h0)) begin fails++; $display("FAIL rand%0d_res: got %h %b %b exp %h %b %b", n, rd, rc, rz, f, co, f == 4'h0); end
            tests++; if (rdy !== 1'b1 || rve !== 1'b0 || rvr !== 1'b1) begin fails++; $display("FAIL rand%0d_hs: got %b%b%b exp 101", n, rdy, rve, rvr); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_backpressure();
        test_load_priority();
        test_rd_eq_ra();
        test_reset_exec();
        test_random();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
